// File: rtl/dsp_result_collector_if.sv
// Result stream between the collector (master) and its consumer (slave):
// valid/ready handshake carrying the masked result and its mode tag.
interface dsp_result_collector_if #(
  parameter int W = 18
);
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic [1:0]   res_mode;

  modport master (output res_valid, output res_data, output res_mode, input res_ready);
  modport slave  (input res_valid, input res_data, input res_mode, output res_ready);
endinterface

// File: rtl/dsp_result_collector.sv
// Captures DSP_top results PIPES cycles after each issue, masks them by mode and queues them.
// Optional accumulator of popped results is enabled by defining COLLECTOR_ACCUM_EN.
module dsp_result_collector #(
  parameter int N     = 9,
  parameter int M     = 9,
  parameter int PIPES = 0,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  input  logic [1:0]                 i_mode,
  input  logic [N+M-1:0]             i_dsp_out,
  dsp_result_collector_if.master     res,
  output logic [$clog2(DEPTH):0]     o_res_count,
  output logic                       o_overflow,
  output logic                       o_bad_mode
`ifdef COLLECTOR_ACCUM_EN
  ,
  input  logic                       i_acc_clr,
  output logic [31:0]                o_acc_sum
`endif
);

  localparam int W  = N + M;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Keep only the result field that the issue mode defines as meaningful.
  function automatic logic [W-1:0] f_mask(input logic [W-1:0] d, input logic [1:0] m);
    logic [W-1:0] r;
    r = '0;
    for (int b = 0; b < W; b++) begin
      if ((m == 2'd2) || ((m == 2'd1) && (b < 15)) || ((m == 2'd0) && (b < 10)))
        r[b] = d[b];
    end
    return r;
  endfunction

  logic       w_tv;
  logic [1:0] w_tm;

  // Stage p0..pN: issue delay line aligned to DSP_top latency
  generate
    if (PIPES == 0) begin : g_nopipe
      assign w_tv = i_start;
      assign w_tm = i_mode;
    end else begin : g_pipe
      logic [PIPES-1:0] r_start_p;
      logic [1:0]       r_mode_p [PIPES];

      always_ff @(posedge clk) begin
        if (rst) begin
          r_start_p <= '0;
          for (int k = 0; k < PIPES; k++) r_mode_p[k] <= '0;
        end else begin
          r_start_p[0] <= i_start;
          r_mode_p[0]  <= i_mode;
          for (int k = 1; k < PIPES; k++) begin
            r_start_p[k] <= r_start_p[k-1];
            r_mode_p[k]  <= r_mode_p[k-1];
          end
        end
      end

      assign w_tv = r_start_p[PIPES-1];
      assign w_tm = r_mode_p[PIPES-1];
    end
  endgenerate

  logic [W-1:0]  r_mem_data [DEPTH];
  logic [1:0]    r_mem_mode [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          r_bad_mode;

  logic          w_valid;
  logic          w_full;
  logic          w_pop;
  logic          w_push_req;
  logic          w_push;
  logic [W-1:0]  w_head;

  assign w_valid    = (r_count != '0);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_pop      = w_valid && res.res_ready;
  assign w_push_req = w_tv && (w_tm != 2'd3) && !rst;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_head     = w_valid ? r_mem_data[r_rd_ptr] : '0;

  // Stage p(PIPES): FIFO control
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_bad_mode <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push_req && !w_push)      r_overflow <= 1'b1;
      if (w_tv && (w_tm == 2'd3))     r_bad_mode <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= f_mask(i_dsp_out, w_tm);
      r_mem_mode[r_wr_ptr] <= w_tm;
    end
  end

  // Outputs are forced to zero whenever the FIFO is empty, including just after reset.
  assign res.res_valid = w_valid;
  assign res.res_data  = w_head;
  assign res.res_mode  = w_valid ? r_mem_mode[r_rd_ptr] : 2'd0;
  assign o_res_count   = r_count;
  assign o_overflow    = r_overflow;
  assign o_bad_mode    = r_bad_mode;

`ifdef COLLECTOR_ACCUM_EN
  logic [31:0] r_acc_sum;

  // Stage p(PIPES+1): running sum of popped results; clear-with-pop loads the popped value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_sum <= '0;
    end else if (i_acc_clr) begin
      r_acc_sum <= w_pop ? 32'(w_head) : 32'd0;
    end else if (w_pop) begin
      r_acc_sum <= r_acc_sum + 32'(w_head);
    end
  end

  assign o_acc_sum = r_acc_sum;
`endif

endmodule

// File: doc/dsp_result_collector.md
DSP_RESULT_COLLECTOR -- requirements
Module: dsp_result_collector

Interface
REQ-001 Parameter N, default 9: operand A width of the attached DSP_top.
REQ-002 Parameter M, default 9: operand B width; result width W = N+M.
REQ-003 Parameter PIPES, default 0: DSP_top pipeline depth in cycles.
REQ-004 Parameter DEPTH, default 4: result FIFO entries, power of two, at least 2.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  issue strobe, the same signal that drives DSP_top.
REQ-008 mode  input  2  issue mode, the same signal that drives DSP_top.
REQ-009 dsp_out  input  W  DSP_top out bus.
REQ-010 res_valid  output  1  FIFO head entry available.
REQ-011 res_ready  input  1  consumer accepts the head entry.
REQ-012 res_data  output  W  head result, masked per mode.
REQ-013 res_mode  output  2  mode tag of the head entry.
REQ-014 res_count  output  log2(DEPTH)+1  FIFO occupancy.
REQ-015 overflow  output  1  sticky flag, set when a result is dropped.
REQ-016 bad_mode  output  1  sticky flag, set when a reserved mode is issued.

Function
REQ-017 A shift register PIPES stages deep SHALL carry {start, mode}; with PIPES=0 it is a wire. Its output is the tap {tv, tm}.
REQ-018 On any edge where tv=1, the block SHALL sample dsp_out; this is the result of the start issued PIPES cycles earlier.
REQ-019 Field masking:
- tm=0: keep dsp_out[9:0], zero the upper bits.
- tm=1: keep dsp_out[14:0], zero the upper bits.
- tm=2: keep dsp_out[W-1:0].
REQ-020 When tm=3 (reserved), the block SHALL push nothing and SHALL set bad_mode.
REQ-021 The masked result and tm SHALL be pushed as one FIFO entry; res_valid rises on the edge after the push.
REQ-022 Pop SHALL occur on an edge with res_valid=1 and res_ready=1; res_data and res_mode SHALL change only on a pop or a push into an empty FIFO.
REQ-023 Push and pop on the same edge with the FIFO not empty: both take effect, and res_count is unchanged.
REQ-024 Push while full:
- with a pop on the same edge, the push is accepted;
- without a pop, the entry is dropped, overflow is set and no stored entry is modified.
REQ-025 Pop while empty SHALL be impossible, because res_valid=0.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; res_count SHALL range over 0..DEPTH.
REQ-027 Issues on consecutive cycles with different modes SHALL keep each mode tag aligned with its own result.
REQ-028 res_valid SHALL equal (res_count != 0).

Reset
REQ-029 While rst=1 at an edge, the block SHALL:
- clear the delay line, both pointers, res_count, overflow, bad_mode and the accumulator;
- drive res_valid=0, res_data=0 and res_mode=0.
REQ-030 Reset mid-operation SHALL discard all in-flight and buffered results.
REQ-031 Results whose start was issued before rst was released SHALL never be pushed.

Configuration
REQ-032 With macro COLLECTOR_ACCUM_EN defined, the block SHALL add output acc_sum (32 bits) and input acc_clr (1 bit).
REQ-033 In that configuration, acc_sum SHALL add the zero-extended res_data on every pop, wrapping modulo 2^32.
REQ-034 In that configuration, acc_clr=1 SHALL zero acc_sum; when acc_clr and a pop coincide, acc_sum SHALL load the popped value.
REQ-035 Without COLLECTOR_ACCUM_EN, the ports acc_sum and acc_clr and all accumulator logic SHALL be absent, and behaviour is otherwise identical.

Verification
REQ-036 PIPES=0, res_ready=1, mode=0, single start with dsp_out=0x3FFFF -> one cycle later res_valid=1, res_data=0x003FF, res_mode=0.
REQ-037 PIPES=2; start with mode=1 at cycle 0 and with mode=2 at cycle 1; dsp_out=0x2ABCD during cycles 2 and 3:
- res_data=0x02BCD with res_mode=1;
- then res_data=0x2ABCD with res_mode=2;
- entries in order.
REQ-038 res_ready=0, six back-to-back starts with mode=2 and DEPTH=4 -> res_count=4, overflow=1, and the first four values are popped intact.
REQ-039 Full FIFO with push and pop on the same edge -> res_count stays 4 and overflow stays 0.
REQ-040 Start with mode=3 -> no push and bad_mode=1; rst=1 for one edge while 3 entries are buffered -> res_valid=0, res_count=0, flags cleared.
REQ-041 COLLECTOR_ACCUM_EN defined; pops of 0x3FF, 0x7FFF and 0x1 -> acc_sum=0x83FF; acc_clr=1 -> acc_sum=0.
